// File: rtl/reg_file_32.sv
// MIPS general-purpose register file: DEPTH x WIDTH, two combinational read ports,
// one write port, hardwired-zero $0, optional same-cycle write-to-read forwarding.
module reg_file_32 #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  s,
  output logic [WIDTH-1:0]  t,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [15:0]       wr_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [15:0]      r_wr_count;
  logic             w_commit;
  logic             w_fwd_s;
  logic             w_fwd_t;

  assign w_commit = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_mem[wr_addr] <= wr_data;
      r_wr_count     <= r_wr_count + 16'd1;
    end
  end

  // Forwarding is suppressed in reset so reads stay at zero while rst_n is low.
  assign w_fwd_s = (BYPASS != 0) && rst_n && w_commit && (rs_addr == wr_addr);
  assign w_fwd_t = (BYPASS != 0) && rst_n && w_commit && (rt_addr == wr_addr);

  always_comb begin
    s        = '0;
    t        = '0;
    dbg_data = '0;
    if (rs_addr != '0)  s        = w_fwd_s ? wr_data : r_mem[rs_addr];
    if (rt_addr != '0)  t        = w_fwd_t ? wr_data : r_mem[rt_addr];
    if (dbg_addr != '0) dbg_data = r_mem[dbg_addr];
  end

  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file_32.sv
// Bench for reg_file_32: table of read/write vectors against a forwarding and a
// non-forwarding instance, plus reset, counter-wrap and full-sweep sequences.
module tb_reg_file_32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] s_b, t_b, dbg_b, s_n, t_n, dbg_n;
  logic [15:0] cnt_b, cnt_n;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  reg_file_32 #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr), .s(s_b), .t(t_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b), .wr_count(cnt_b)
  );

  reg_file_32 #(.BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr), .s(s_n), .t(t_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_n), .wr_count(cnt_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, dbg;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_s, exp_t, exp_dbg;
    logic [15:0] exp_cnt;
    logic [31:0] exp_s_n, exp_t_n;
  } vec_t;

  vec_t vecs[8];

  // driver tasks
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg,
                       input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
    rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
    wr_en = wen; wr_addr = waddr; wr_data = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: actual %h, expected value missing from queue", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: actual %h required %h", nm, act, e);
      end
    end
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd1, 1'b1, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0};
    vecs[1] = '{5'd1, 5'd2, 5'd2, 1'b1, 5'd2, 32'd2, 32'd1, 32'd2, 32'd0, 16'd1, 32'd1, 32'd0};
    vecs[2] = '{5'd1, 5'd2, 5'd2, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 32'd2, 16'd2, 32'd1, 32'd2};
    vecs[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 16'd2, 32'd0, 32'd0};
    vecs[4] = '{5'd3, 5'd1, 5'd3, 1'b1, 5'd3, 32'd7, 32'd7, 32'd1, 32'd0, 16'd2, 32'd0, 32'd1};
    vecs[5] = '{5'd3, 5'd3, 5'd3, 1'b1, 5'd3, 32'd9, 32'd9, 32'd9, 32'd7, 16'd3, 32'd7, 32'd7};
    vecs[6] = '{5'd3, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 32'd9, 32'd9, 32'd9, 16'd4, 32'd9, 32'd9};
    vecs[7] = '{5'd5, 5'd0, 5'd5, 1'b0, 5'd5, 32'h55, 32'd0, 32'd0, 32'd0, 16'd4, 32'd0, 32'd0};

    rst_n = 1'b0;
    drive(5'd1, 5'd2, 5'd1, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(32'd0); chk("reset_s", s_b);
    exp_q.push_back(32'd0); chk("reset_t", t_b);
    exp_q.push_back(32'd0); chk("reset_cnt", {16'd0, cnt_b});
    rst_n = 1'b1;
    tick();

    // table-driven vectors: expectations are the values seen before the committing edge
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].dbg, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
      exp_q.push_back(vecs[i].exp_s);
      exp_q.push_back(vecs[i].exp_t);
      exp_q.push_back(vecs[i].exp_dbg);
      exp_q.push_back({16'd0, vecs[i].exp_cnt});
      exp_q.push_back(vecs[i].exp_s_n);
      exp_q.push_back(vecs[i].exp_t_n);
      @(negedge clk);
      chk($sformatf("v%0d_s", i), s_b);
      chk($sformatf("v%0d_t", i), t_b);
      chk($sformatf("v%0d_dbg", i), dbg_b);
      chk($sformatf("v%0d_cnt", i), {16'd0, cnt_b});
      chk($sformatf("v%0d_s_nobyp", i), s_n);
      chk($sformatf("v%0d_t_nobyp", i), t_n);
      tick();
    end

    // operands for an add: $1 + $2
    drive(5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(32'd3);
    @(negedge clk);
    chk("alu_sum", s_b + t_b);
    tick();

    // asynchronous reset mid-cycle, held across an edge with a write pending
    drive(5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive(5'd5, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    #2 chk("pre_reset_s", s_b);
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 32'h1234_5678);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    chk("in_reset_s", s_b);
    chk("in_reset_t", t_b);
    chk("in_reset_dbg", dbg_b);
    chk("in_reset_cnt", {16'd0, cnt_b});
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    chk("after_reset_s", s_b);
    chk("after_reset_cnt", {16'd0, cnt_b});
    tick();

    // counter wrap over 65536 commits to nonzero addresses
    for (int k = 0; k < 65536; k++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b1, 5'(k % 31 + 1), k);
      tick();
      if (k == 65534) begin
        exp_q.push_back(32'h0000_FFFF);
        chk("cnt_ffff", {16'd0, cnt_b});
      end
    end
    wr_en = 1'b0;
    exp_q.push_back(32'd0);
    #1 chk("cnt_wrap", {16'd0, cnt_b});

    // full sweep of writable registers
    for (int i = 1; i < 32; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b1, 5'(i), 32'h1000 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(5'(i), 5'(i), 5'(i), 1'b0, 5'd0, 32'd0);
      exp_q.push_back(32'h1000 + i);
      exp_q.push_back(32'h1000 + i);
      exp_q.push_back(32'h1000 + i);
      exp_q.push_back(32'h1000 + i);
      #2;
      chk($sformatf("sweep%0d_s", i), s_b);
      chk($sformatf("sweep%0d_t", i), t_b);
      chk($sformatf("sweep%0d_dbg", i), dbg_b);
      chk($sformatf("sweep%0d_dbg_nobyp", i), dbg_n);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back(32'd0);
    #2 chk("sweep_zero", s_b);

    // final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
